// File: rtl/dsp_simd2x_pair_scheduler.sv
// Pairs shared-coefficient multiply requests onto one SIMD 2x INT9xUINT8 DSP slice and
// splits the packed 48b product back into two tagged lane results on a valid/ready stream.
module dsp_simd2x_pair_scheduler #(
    parameter int DSP_LATENCY  = 3,
    parameter int TAG_W        = 8,
    parameter int HOLD_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [8:0]       s_coef,
    input  logic [7:0]       s_pixel,
    input  logic [TAG_W-1:0] s_tag,
    input  logic             s_last,
    output logic             dsp_clken,
    output logic [8:0]       dsp_coef,
    output logic [25:0]      dsp_pack,
    input  logic [47:0]      dsp_p,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [17:0]      m_low,
    output logic [17:0]      m_high,
    output logic [1:0]       m_mask,
    output logic [TAG_W-1:0] m_tag_lo,
    output logic [TAG_W-1:0] m_tag_hi
);
    localparam int PL = DSP_LATENCY;

    typedef enum logic {ST_EMPTY = 1'b0, ST_HELD = 1'b1} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    w_en, w_acc;
    logic signed [8:0]       r_h_coef;
    logic [7:0]              r_h_pix;
    logic [TAG_W-1:0]        r_h_tag;
    logic                    r_h_last;
    logic [3:0]              r_cnt, w_cnt_nxt;
    logic                    w_iss, w_cap;
    logic signed [8:0]       w_iss_coef;
    logic [7:0]              w_iss_lo, w_iss_hi;
    logic [1:0]              w_iss_mask;
    logic [TAG_W-1:0]        w_iss_tlo, w_iss_thi;
    logic signed [8:0]       r_dsp_coef_p0;
    logic [25:0]             r_dsp_pack_p0;
    logic                    r_vld_p  [0:PL];
    logic [1:0]              r_mask_p [0:PL];
    logic [TAG_W-1:0]        r_tlo_p  [0:PL];
    logic [TAG_W-1:0]        r_thi_p  [0:PL];
    logic                    r_m_valid;
    logic signed [17:0]      r_m_low, r_m_high;
    logic [1:0]              r_m_mask;
    logic [TAG_W-1:0]        r_m_tag_lo, r_m_tag_hi;
    logic                    w_unused_p_top;

    // The low lane's sign borrows one from the high lane; adding bit 17 back undoes it.
    function automatic logic signed [17:0] f_split_hi(input logic [47:0] p, input logic used);
        logic signed [17:0] v;
        v = p[35:18] + {17'd0, p[17]};
        return used ? v : 18'sd0;
    endfunction

    assign w_en      = aresetn && (!r_m_valid || m_ready);
    assign w_acc     = s_valid && w_en;
    assign s_ready   = w_en;
    assign dsp_clken = w_en;
    assign w_unused_p_top = ^dsp_p[47:36];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_iss       = 1'b0;
        w_cap       = 1'b0;
        w_iss_coef  = r_h_coef;
        w_iss_lo    = r_h_pix;
        w_iss_hi    = 8'd0;
        w_iss_mask  = 2'b01;
        w_iss_tlo   = r_h_tag;
        w_iss_thi   = '0;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    if (s_last) begin
                        w_iss      = 1'b1;
                        w_iss_coef = $signed(s_coef);
                        w_iss_lo   = s_pixel;
                        w_iss_tlo  = s_tag;
                    end else begin
                        w_cap       = 1'b1;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (w_acc) begin
                    w_iss     = 1'b1;
                    w_cnt_nxt = 4'd0;
                    if ((s_coef == r_h_coef) && !r_h_last) begin
                        w_iss_hi    = s_pixel;
                        w_iss_mask  = 2'b11;
                        w_iss_thi   = s_tag;
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_cap = 1'b1;
                    end
                end else if (r_h_last || (r_cnt == 4'(HOLD_TIMEOUT - 1))) begin
                    w_iss       = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Request hold stage
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ST_EMPTY;
            r_cnt    <= 4'd0;
            r_h_coef <= '0;
            r_h_pix  <= '0;
            r_h_tag  <= '0;
            r_h_last <= 1'b0;
        end else if (w_en) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_cap) begin
                r_h_coef <= $signed(s_coef);
                r_h_pix  <= s_pixel;
                r_h_tag  <= s_tag;
                r_h_last <= s_last;
            end
        end
    end

    // p0: DSP operands; p1..pPL: sideband aligned with dsp_p
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_dsp_coef_p0 <= '0;
            r_dsp_pack_p0 <= '0;
            for (int i = 0; i <= PL; i++) begin
                r_vld_p[i]  <= 1'b0;
                r_mask_p[i] <= 2'b00;
                r_tlo_p[i]  <= '0;
                r_thi_p[i]  <= '0;
            end
        end else if (w_en) begin
            if (w_iss) r_dsp_coef_p0 <= w_iss_coef;
            r_dsp_pack_p0 <= w_iss ? {w_iss_hi, 10'd0, w_iss_lo} : 26'd0;
            r_vld_p[0]    <= w_iss;
            r_mask_p[0]   <= w_iss ? w_iss_mask : 2'b00;
            r_tlo_p[0]    <= w_iss ? w_iss_tlo : '0;
            r_thi_p[0]    <= w_iss ? w_iss_thi : '0;
            for (int i = 1; i <= PL; i++) begin
                r_vld_p[i]  <= r_vld_p[i-1];
                r_mask_p[i] <= r_mask_p[i-1];
                r_tlo_p[i]  <= r_tlo_p[i-1];
                r_thi_p[i]  <= r_thi_p[i-1];
            end
        end
    end

    // Output stage
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_valid  <= 1'b0;
            r_m_low    <= '0;
            r_m_high   <= '0;
            r_m_mask   <= 2'b00;
            r_m_tag_lo <= '0;
            r_m_tag_hi <= '0;
        end else if (w_en) begin
            r_m_valid <= r_vld_p[PL];
            if (r_vld_p[PL]) begin
                r_m_low    <= $signed(dsp_p[17:0]);
                r_m_high   <= f_split_hi(dsp_p, r_mask_p[PL][1]);
                r_m_mask   <= r_mask_p[PL];
                r_m_tag_lo <= r_tlo_p[PL];
                r_m_tag_hi <= r_thi_p[PL];
            end
        end
    end

    assign dsp_coef = r_dsp_coef_p0;
    assign dsp_pack = r_dsp_pack_p0;
    assign m_valid  = r_m_valid;
    assign m_low    = r_m_low;
    assign m_high   = r_m_high;
    assign m_mask   = r_m_mask;
    assign m_tag_lo = r_m_tag_lo;
    assign m_tag_hi = r_m_tag_hi;
endmodule
